// File: rtl/reg_desp_pkg.sv
// Shared encodings for the multi-step universal shift register.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package reg_desp_pkg;

    // Operating modes carried on MODO
    localparam logic [1:0] MODO_SHIFT = 2'b00;
    localparam logic [1:0] MODO_ROT   = 2'b01;
    localparam logic [1:0] MODO_LOAD  = 2'b10;
    localparam logic [1:0] MODO_ASHR  = 2'b11;

    // Shift direction: left moves bits towards the MSB
    localparam logic DIR_IZQ = 1'b0;
    localparam logic DIR_DER = 1'b1;

    // Controller states; DONE is a registered pulse, not a state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A non-load command with a zero step count completes without running
    function automatic logic cmd_runs(input logic [1:0] modo, input logic cnt_nonzero);
        return (modo != MODO_LOAD) && cnt_nonzero;
    endfunction

endpackage

// File: rtl/reg_desp_step.sv
// Single-bit-position step of the universal shift register (next Q and exit bit).
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides whether to commit the result.
module reg_desp_step
    import reg_desp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       modo,
    input  logic             dir,
    input  logic             s_in,
    output logic [WIDTH-1:0] q_next,
    output logic             bit_out
);

    // Compute the shifted/rotated value and the bit that falls off the end
    always_comb begin
        q_next  = q;
        bit_out = 1'b0;
        case (modo)
            MODO_SHIFT: begin
                if (dir == DIR_IZQ) begin
                    q_next  = {q[WIDTH-2:0], s_in};
                    bit_out = q[WIDTH-1];
                end else begin
                    q_next  = {s_in, q[WIDTH-1:1]};
                    bit_out = q[0];
                end
            end
            MODO_ROT: begin
                if (dir == DIR_IZQ) begin
                    q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                    bit_out = q[WIDTH-1];
                end else begin
                    q_next  = {q[0], q[WIDTH-1:1]};
                    bit_out = q[0];
                end
            end
            MODO_ASHR: begin
                // Arithmetic left is a logical left with zero fill; right keeps the sign
                if (dir == DIR_IZQ) begin
                    q_next  = {q[WIDTH-2:0], 1'b0};
                    bit_out = q[WIDTH-1];
                end else begin
                    q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                    bit_out = q[0];
                end
            end
            default: begin
                // Load never steps; keep the register as it is
                q_next  = q;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_desp_multi.sv
// Universal shift register executing a latched multi-step command, one bit per clock.
// Latency: load / zero-count done one cycle after START; n-step command done after n+1 edges.
// Backpressure: ENB=0 pauses a running command and blocks START; START while BUSY is dropped.
module reg_desp_multi
    import reg_desp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENB,
    input  logic             START,
    input  logic [1:0]       MODO,
    input  logic             DIR,
    input  logic [CNT_W-1:0] CNT,
    input  logic             S_IN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_nxt;
    logic [1:0]       modo_q;
    logic             dir_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] q_reg;
    logic             s_out_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH-1:0] step_q;
    logic             step_bit;
    logic             accept;
    logic             step_en;
    logic             last_step;

    reg_desp_step #(.WIDTH(WIDTH)) u_step (
        .q       (q_reg),
        .modo    (modo_q),
        .dir     (dir_q),
        .s_in    (S_IN),
        .q_next  (step_q),
        .bit_out (step_bit)
    );

    // Next-state and qualifier decode for the IDLE/RUN controller
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        step_en   = 1'b0;
        last_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                accept = ENB && START;
                if (accept && cmd_runs(MODO, CNT != '0)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                step_en   = ENB;
                last_step = ENB && (cnt_q == CNT_ONE);
                if (last_step) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Controller state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Command latch, step counter, data registers and handshake outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            modo_q    <= MODO_SHIFT;
            dir_q     <= DIR_IZQ;
            cnt_q     <= '0;
            q_reg     <= '0;
            s_out_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                modo_q <= MODO;
                dir_q  <= DIR;
                cnt_q  <= CNT;
                if (MODO == MODO_LOAD) begin
                    q_reg    <= D;
                    done_reg <= 1'b1;
                end else if (CNT == '0) begin
                    done_reg <= 1'b1;
                end else begin
                    busy_reg <= 1'b1;
                end
            end
            if (step_en) begin
                q_reg     <= step_q;
                s_out_reg <= step_bit;
                cnt_q     <= cnt_q - CNT_ONE;
                if (last_step) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign Q     = q_reg;
    assign S_OUT = s_out_reg;
    assign BUSY  = busy_reg;
    assign DONE  = done_reg;

endmodule

// File: tb/tb_reg_desp_multi.sv
// Directed bench for reg_desp_multi with a per-cycle expectation queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_desp_multi;

    logic       CLK = 1'b0;
    logic       RST, ENB, START, DIR, S_IN;
    logic [1:0] MODO;
    logic [3:0] CNT;
    logic [7:0] D;
    logic [7:0] Q;
    logic       S_OUT, BUSY, DONE;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] q;
        logic       s;
        logic       b;
        logic       d;
        string      tag;
    } exp_t;

    exp_t sb[$];

    reg_desp_multi #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .ENB   (ENB),
        .START (START),
        .MODO  (MODO),
        .DIR   (DIR),
        .CNT   (CNT),
        .S_IN  (S_IN),
        .D     (D),
        .Q     (Q),
        .S_OUT (S_OUT),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    // Push the expected post-edge outputs, clock once, then pop and compare
    task automatic cyc(input string tag, input logic [7:0] q, input logic s,
                       input logic b, input logic d);
        exp_t e;
        e.q = q; e.s = s; e.b = b; e.d = d; e.tag = tag;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        checks++;
        assert (Q === e.q) else begin
            errors++;
            $error("FAIL %s.Q got %h exp %h", e.tag, Q, e.q);
        end
        checks++;
        assert (S_OUT === e.s) else begin
            errors++;
            $error("FAIL %s.S_OUT got %b exp %b", e.tag, S_OUT, e.s);
        end
        checks++;
        assert (BUSY === e.b) else begin
            errors++;
            $error("FAIL %s.BUSY got %b exp %b", e.tag, BUSY, e.b);
        end
        checks++;
        assert (DONE === e.d) else begin
            errors++;
            $error("FAIL %s.DONE got %b exp %b", e.tag, DONE, e.d);
        end
    endtask

    task automatic cmd(input logic [1:0] m, input logic dr, input logic [3:0] n,
                       input logic si, input logic [7:0] dd);
        START = 1'b1; MODO = m; DIR = dr; CNT = n; S_IN = si; D = dd;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        RST = 1'b1; ENB = 1'b1; START = 1'b0; MODO = 2'b00; DIR = 1'b0;
        CNT = 4'd0; S_IN = 1'b0; D = 8'h00;
        #1;
        cyc("rst0", 8'h00, 0, 0, 0);
        cyc("rst1", 8'h00, 0, 0, 0);
        RST = 1'b0;

        // 1: parallel load
        cmd(2'b10, 0, 4'd0, 0, 8'hA5);
        cyc("ld_k", 8'hA5, 0, 0, 1);
        START = 1'b0;
        cyc("ld_idle", 8'hA5, 0, 0, 0);

        // 2: shift left by 3 with S_IN=1
        cmd(2'b00, 0, 4'd3, 1, 8'h00);
        cyc("shl_k", 8'hA5, 0, 1, 0);
        START = 1'b0;
        cyc("shl_1", 8'h4B, 1, 1, 0);
        cyc("shl_2", 8'h97, 0, 1, 0);
        cyc("shl_3", 8'h2F, 1, 0, 1);
        cyc("shl_idle", 8'h2F, 1, 0, 0);

        // 3: rotate right by 4, then a load in the DONE cycle, then arith right by 2
        cmd(2'b10, 0, 4'd0, 0, 8'hA5);
        cyc("ld2", 8'hA5, 1, 0, 1);
        cmd(2'b01, 1, 4'd4, 0, 8'h00);
        cyc("ror_k", 8'hA5, 1, 1, 0);
        START = 1'b0;
        cyc("ror_1", 8'hD2, 1, 1, 0);
        cyc("ror_2", 8'h69, 0, 1, 0);
        cyc("ror_3", 8'hB4, 1, 1, 0);
        cmd(2'b10, 0, 4'd0, 0, 8'h90);
        START = 1'b0;
        cyc("ror_4", 8'h5A, 0, 0, 1);
        cmd(2'b10, 0, 4'd0, 0, 8'h90);
        cyc("ld_in_done", 8'h90, 0, 0, 1);
        cmd(2'b11, 1, 4'd2, 1, 8'h00);
        cyc("asr_k", 8'h90, 0, 1, 0);
        START = 1'b0;
        cyc("asr_1", 8'hC8, 0, 1, 0);
        cyc("asr_2", 8'hE4, 0, 0, 1);
        cyc("asr_idle", 8'hE4, 0, 0, 0);

        // 4: pause mid shift-left by 3; START and input changes during BUSY ignored
        cmd(2'b00, 0, 4'd3, 0, 8'h00);
        cyc("pz_k", 8'hE4, 0, 1, 0);
        START = 1'b0;
        cyc("pz_1", 8'hC8, 1, 1, 0);
        ENB = 1'b0;
        cmd(2'b10, 1, 4'd1, 0, 8'hFF);
        S_IN = 1'b0;
        cyc("pz_hold1", 8'hC8, 1, 1, 0);
        cyc("pz_hold2", 8'hC8, 1, 1, 0);
        ENB = 1'b1;
        cyc("pz_2", 8'h90, 1, 1, 0);
        START = 1'b0;
        cyc("pz_3", 8'h20, 1, 0, 1);
        cyc("pz_idle", 8'h20, 1, 0, 0);

        // 5: zero-count shift leaves Q alone but still pulses DONE
        cmd(2'b10, 0, 4'd0, 0, 8'h3C);
        cyc("ld3c", 8'h3C, 1, 0, 1);
        cmd(2'b00, 0, 4'd0, 1, 8'h00);
        cyc("cnt0", 8'h3C, 1, 0, 1);
        START = 1'b0;
        cyc("cnt0_idle", 8'h3C, 1, 0, 0);

        // ENB=0 in IDLE blocks START
        ENB = 1'b0;
        cmd(2'b10, 0, 4'd0, 0, 8'h11);
        cyc("enb0_idle", 8'h3C, 1, 0, 0);
        START = 1'b0; ENB = 1'b1;

        // 6: reset in the middle of a 5-step shift
        cmd(2'b00, 0, 4'd5, 0, 8'h00);
        cyc("rs_k", 8'h3C, 1, 1, 0);
        START = 1'b0;
        cyc("rs_1", 8'h78, 0, 1, 0);
        cyc("rs_2", 8'hF0, 0, 1, 0);
        RST = 1'b1;
        cyc("rs_hit", 8'h00, 0, 0, 0);
        RST = 1'b0;
        cyc("rs_idle", 8'h00, 0, 0, 0);
        cmd(2'b10, 0, 4'd0, 0, 8'h5A);
        cyc("rs_ld", 8'h5A, 0, 0, 1);
        START = 1'b0;
        cyc("rs_ld_idle", 8'h5A, 0, 0, 0);

        // Logical shift right with S_IN=1, then arithmetic left forcing zero fill
        cmd(2'b00, 1, 4'd2, 1, 8'h00);
        cyc("shr_k", 8'h5A, 0, 1, 0);
        START = 1'b0;
        cyc("shr_1", 8'hAD, 0, 1, 0);
        cyc("shr_2", 8'hD6, 1, 0, 1);
        cmd(2'b11, 0, 4'd1, 1, 8'h00);
        cyc("asl_k", 8'hD6, 1, 1, 0);
        START = 1'b0;
        cyc("asl_1", 8'hAC, 1, 0, 1);
        cyc("asl_idle", 8'hAC, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
